accumulator_unit: RTL

ACCUMULATOR_UNIT -- requirements
Module: accumulator_unit

---
 rtl/bascomp_pkg.sv | 23 ++
 rtl/sixteenbitadder.sv | 21 ++
 rtl/accumulator_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bascomp_pkg.sv
// Basic-computer accumulator shared constants.
// Opcode values and FSM state encoding.
package bascomp_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_LDA = 4'h3;
  localparam logic [3:0] OP_CLA = 4'h4;
  localparam logic [3:0] OP_CLE = 4'h5;
  localparam logic [3:0] OP_CMA = 4'h6;
  localparam logic [3:0] OP_CME = 4'h7;
  localparam logic [3:0] OP_CIR = 4'h8;
  localparam logic [3:0] OP_CIL = 4'h9;
  localparam logic [3:0] OP_INC = 4'hA;
  localparam logic [3:0] OP_INP = 4'hB;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/sixteenbitadder.sv
// 16-bit ripple adder shared by ADD and INC.
// Produces sum and carry out.
module sixteenbitadder (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [16:0] full;

  // 17-bit sum so the carry falls out of the top bit
  always_comb begin
    full = {1'b0, a_i} + {1'b0, b_i} + {16'b0, cin_i};
  end

  assign sum_o  = full[15:0];
  assign cout_o = full[16];

endmodule

// File: rtl/accumulator_unit.sv
// Accumulator (AC) and extend flip-flop (E) execution unit.
// Two-state FSM: accept in IDLE, commit result on EXEC->IDLE edge.
module accumulator_unit
  import bascomp_pkg::*;
#(
  parameter logic [15:0] AC_RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op_code,
  input  logic [15:0] dr_in,
  input  logic [7:0]  inpr_in,
  output logic        op_ready,
  output logic [15:0] ac_out,
  output logic        e_out,
  output logic        done,
  output logic        illegal_op,
  output logic        ac_zero
);

  state_e      state_q, state_d;
  logic [3:0]  op_q;
  logic [15:0] dr_q;
  logic [7:0]  inpr_q;
  logic [15:0] ac_q, ac_d;
  logic        e_q, e_d;
  logic        done_q;
  logic        illegal_q;

  logic        accept;
  logic        in_exec;
  logic        rsvd;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic        add_cout;

  assign accept  = (state_q == ST_IDLE) && op_valid;
  assign in_exec = (state_q == ST_EXEC);
  assign rsvd    = op_q[3] & op_q[2];

  // Operand B: latched DR for ADD, constant one for INC
  assign add_b = (op_q == OP_ADD) ? dr_q : 16'h0001;

  sixteenbitadder u_adder (
    .a_i    (ac_q),
    .b_i    (add_b),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: accept in IDLE, always return from EXEC
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (op_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    op_ready = (state_q == ST_IDLE);
  end

  // Capture operands on the acceptance edge only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= OP_NOP;
      dr_q   <= '0;
      inpr_q <= '0;
    end else if (accept) begin
      op_q   <= op_code;
      dr_q   <= dr_in;
      inpr_q <= inpr_in;
    end
  end

  // Next AC/E from the latched opcode
  always_comb begin
    ac_d = ac_q;
    e_d  = e_q;
    unique case (op_q)
      OP_AND: ac_d = ac_q & dr_q;
      OP_ADD: begin
        ac_d = add_sum;
        e_d  = add_cout;
      end
      OP_LDA: ac_d = dr_q;
      OP_CLA: ac_d = '0;
      OP_CLE: e_d  = 1'b0;
      OP_CMA: ac_d = ~ac_q;
      OP_CME: e_d  = ~e_q;
      OP_CIR: begin
        ac_d = {e_q, ac_q[15:1]};
        e_d  = ac_q[0];
      end
      OP_CIL: begin
        ac_d = {ac_q[14:0], e_q};
        e_d  = ac_q[15];
      end
      OP_INC: ac_d = add_sum;
      OP_INP: ac_d = {ac_q[15:8], inpr_q};
      default: begin
        ac_d = ac_q;
        e_d  = e_q;
      end
    endcase
  end

  // Commit result and raise one-cycle status pulses on leaving EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ac_q      <= AC_RESET_VAL;
      e_q       <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      if (in_exec) begin
        ac_q      <= ac_d;
        e_q       <= e_d;
        done_q    <= 1'b1;
        illegal_q <= rsvd;
      end
    end
  end

  assign ac_out     = ac_q;
  assign e_out      = e_q;
  assign done       = done_q;
  assign illegal_op = illegal_q;
  assign ac_zero    = (ac_q == 16'h0000);

endmodule
